// File: rtl/jesd_pattern_checker_if.sv
// Bus bundle between the JESD receive path and the loopback pattern checker.
// master = word source / control side, slave = the checker itself.
interface jesd_pattern_checker_if #(
    parameter int ERRCNT_W = 16
);
    logic [31:0]         DATA_IN;
    logic                DATA_VALID;
    logic                CLR;
    logic                LOCKED;
    logic                ERR_PULSE;
    logic [ERRCNT_W-1:0] ERR_COUNT;
    logic [31:0]         WORD_COUNT;
    logic [31:0]         LAST_BAD;
    logic                DBG_STATE;

    // DATA_IN is consumed on every rising clock edge where DATA_VALID is high;
    // the checker never stalls, so there is no ready and no back-pressure.
    modport master (
        output DATA_IN, DATA_VALID, CLR,
        input  LOCKED, ERR_PULSE, ERR_COUNT, WORD_COUNT, LAST_BAD, DBG_STATE
    );

    modport slave (
        input  DATA_IN, DATA_VALID, CLR,
        output LOCKED, ERR_PULSE, ERR_COUNT, WORD_COUNT, LAST_BAD, DBG_STATE
    );
endinterface

// File: rtl/jesd_pattern_checker.sv
// RX-side checker for the {18'b0, count[9:0], 4'b1010} loopback pattern:
// acquires lock on the count sequence, then counts and captures mismatches.
module jesd_pattern_checker #(
    parameter int LOCK_THRESH   = 4,
    parameter int UNLOCK_THRESH = 3,
    parameter int ERRCNT_W      = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    jesd_pattern_checker_if.slave  bus
);
    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [3:0]          LOCK_T   = 4'(LOCK_THRESH);
    localparam logic [3:0]          UNLOCK_T = 4'(UNLOCK_THRESH);
    localparam logic [ERRCNT_W-1:0] ERR_ONE  = {{(ERRCNT_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [9:0]          r_expected;
    logic [3:0]          r_good_run;
    logic [3:0]          r_bad_run;
    logic                r_err_pulse;
    logic [ERRCNT_W-1:0] r_err_count;
    logic [31:0]         r_word_count;
    logic [31:0]         r_last_bad;

    logic       w_sample;
    logic       w_well;
    logic [9:0] w_rx_cnt;
    logic       w_match;
    logic       w_err;
    logic [3:0] w_good_nxt;
    logic [3:0] w_bad_nxt;

    // Blank words are trigger blanking from the generator and are invisible here.
    always_comb begin
        w_sample   = bus.DATA_VALID && (bus.DATA_IN != 32'd0);
        w_well     = (bus.DATA_IN[31:14] == 18'd0) && (bus.DATA_IN[3:0] == 4'b1010);
        w_rx_cnt   = bus.DATA_IN[13:4];
        w_match    = (w_rx_cnt == r_expected);
        w_err      = w_sample && (r_state == ST_LOCKED) && !(w_well && w_match);
        w_good_nxt = r_good_run + 4'd1;
        w_bad_nxt  = r_bad_run + 4'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= ST_SEARCH;
            r_expected   <= 10'd0;
            r_good_run   <= 4'd0;
            r_bad_run    <= 4'd0;
            r_err_pulse  <= 1'b0;
            r_err_count  <= '0;
            r_word_count <= 32'd0;
            r_last_bad   <= 32'd0;
        end else begin
            r_err_pulse <= w_err;
            if (w_sample) begin
                if (r_state == ST_SEARCH) begin
                    if (w_well) begin
                        r_expected <= w_rx_cnt + 10'd1;
                        if (w_match && (r_good_run != 4'd0)) begin
                            r_good_run <= w_good_nxt;
                            if (w_good_nxt == LOCK_T) begin
                                r_state   <= ST_LOCKED;
                                r_bad_run <= 4'd0;
                            end
                        end else begin
                            r_good_run <= 4'd1;
                        end
                    end else begin
                        r_good_run <= 4'd0;
                    end
                end else begin
                    if (r_word_count != 32'hFFFF_FFFF)
                        r_word_count <= r_word_count + 32'd1;
                    if (w_well && w_match) begin
                        r_expected <= r_expected + 10'd1;
                        r_bad_run  <= 4'd0;
                    end else begin
                        // A well-formed slip resyncs so it is counted only once.
                        r_expected <= w_well ? (w_rx_cnt + 10'd1) : (r_expected + 10'd1);
                        r_bad_run  <= w_bad_nxt;
                        r_last_bad <= bus.DATA_IN;
                        if (r_err_count != '1)
                            r_err_count <= r_err_count + ERR_ONE;
                        if (w_bad_nxt == UNLOCK_T) begin
                            r_state    <= ST_SEARCH;
                            r_good_run <= 4'd0;
                        end
                    end
                end
            end
            if (bus.CLR) begin
                r_err_count  <= '0;
                r_word_count <= 32'd0;
                r_last_bad   <= 32'd0;
            end
        end
    end

    assign bus.LOCKED     = (r_state == ST_LOCKED);
    assign bus.DBG_STATE  = r_state;
    assign bus.ERR_PULSE  = r_err_pulse;
    assign bus.ERR_COUNT  = r_err_count;
    assign bus.WORD_COUNT = r_word_count;
    assign bus.LAST_BAD   = r_last_bad;
endmodule

// File: tb/tb_jesd_pattern_checker.sv
// Directed bench for jesd_pattern_checker: lock, wrap, slip, blanking,
// loss of lock, CLR and asynchronous reset.
module tb_jesd_pattern_checker;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_q[$];

    jesd_pattern_checker_if #(.ERRCNT_W(16)) bus ();

    jesd_pattern_checker #(
        .LOCK_THRESH   (4),
        .UNLOCK_THRESH (3),
        .ERRCNT_W      (16)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [9:0] c);
        return {18'd0, c, 4'b1010};
    endfunction

    // Every observed error pulse must correspond to a queued expected LAST_BAD.
    task automatic mon_err();
        if (bus.ERR_PULSE === 1'b1) begin
            if (exp_q.size() == 0) check_val("unexpected_err", 32'd1, 32'd0);
            else check_val("last_bad", bus.LAST_BAD, exp_q.pop_front());
        end
    endtask

    task automatic send(input logic [31:0] d);
        bus.DATA_IN    = d;
        bus.DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
        bus.DATA_VALID = 1'b0;
        bus.DATA_IN    = 32'd0;
        mon_err();
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        mon_err();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_locked"}, {31'd0, bus.LOCKED}, 32'd0);
        check_val({tag, "_pulse"}, {31'd0, bus.ERR_PULSE}, 32'd0);
        check_val({tag, "_errcnt"}, {16'd0, bus.ERR_COUNT}, 32'd0);
        check_val({tag, "_wordcnt"}, bus.WORD_COUNT, 32'd0);
        check_val({tag, "_lastbad"}, bus.LAST_BAD, 32'd0);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog obs=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.DATA_IN    = 32'd0;
        bus.DATA_VALID = 1'b0;
        bus.CLR        = 1'b0;
        #1;
        check_all_zero("reset");
        check_val("reset_state", {31'd0, bus.DBG_STATE}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Clean stream: lock after the 4th in-sequence word.
        send(mk(10'd0));
        send(mk(10'd1));
        send(mk(10'd2));
        check_val("pre_lock", {31'd0, bus.LOCKED}, 32'd0);
        send(mk(10'd3));
        check_val("lock", {31'd0, bus.LOCKED}, 32'd1);
        check_val("lock_state", {31'd0, bus.DBG_STATE}, 32'd1);
        check_val("lock_wordcnt", bus.WORD_COUNT, 32'd0);
        send(mk(10'd4));
        check_val("first_counted", bus.WORD_COUNT, 32'd1);
        for (int i = 5; i <= 9; i++) send(mk(10'(i)));
        check_val("clean_wordcnt", bus.WORD_COUNT, 32'd6);
        check_val("clean_errcnt", {16'd0, bus.ERR_COUNT}, 32'd0);

        // Single slip: expected 10, inject 12, then 13, 14.
        exp_q.push_back(32'h0000_00CA);
        send(mk(10'd12));
        check_val("slip_pulse", {31'd0, bus.ERR_PULSE}, 32'd1);
        check_val("slip_errcnt", {16'd0, bus.ERR_COUNT}, 32'd1);
        check_val("slip_lastbad", bus.LAST_BAD, 32'h0000_00CA);
        check_val("slip_locked", {31'd0, bus.LOCKED}, 32'd1);
        send(mk(10'd13));
        check_val("slip_pulse_off", {31'd0, bus.ERR_PULSE}, 32'd0);
        send(mk(10'd14));
        check_val("slip_errcnt_hold", {16'd0, bus.ERR_COUNT}, 32'd1);
        check_val("slip_wordcnt", bus.WORD_COUNT, 32'd9);

        // Blanking after count 20; idle cycles in the middle as well.
        for (int i = 15; i <= 20; i++) send(mk(10'(i)));
        check_val("pre_blank_wordcnt", bus.WORD_COUNT, 32'd15);
        for (int i = 0; i < 5; i++) begin
            send(32'd0);
            check_val("blank_wordcnt", bus.WORD_COUNT, 32'd15);
        end
        idle();
        idle();
        send(mk(10'd21));
        check_val("post_blank_pulse", {31'd0, bus.ERR_PULSE}, 32'd0);
        check_val("post_blank_wordcnt", bus.WORD_COUNT, 32'd16);
        check_val("post_blank_errcnt", {16'd0, bus.ERR_COUNT}, 32'd1);

        // Wrap through 1023 -> 0.
        for (int i = 22; i <= 1023; i++) send(mk(10'(i)));
        check_val("wrap_last", bus.WORD_COUNT, 32'd1018);
        send(mk(10'd0));
        send(mk(10'd1));
        check_val("wrap_errcnt", {16'd0, bus.ERR_COUNT}, 32'd1);
        check_val("wrap_locked", {31'd0, bus.LOCKED}, 32'd1);
        check_val("wrap_wordcnt", bus.WORD_COUNT, 32'd1020);

        // CLR on its own leaves lock alone.
        bus.CLR = 1'b1;
        idle();
        bus.CLR = 1'b0;
        check_val("clr_errcnt", {16'd0, bus.ERR_COUNT}, 32'd0);
        check_val("clr_wordcnt", bus.WORD_COUNT, 32'd0);
        check_val("clr_lastbad", bus.LAST_BAD, 32'd0);
        check_val("clr_locked", {31'd0, bus.LOCKED}, 32'd1);

        // Loss of lock on three malformed words.
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(32'h1234_5678);
            send(32'h1234_5678);
            check_val("lol_errcnt", {16'd0, bus.ERR_COUNT}, 32'(i));
            check_val("lol_locked", {31'd0, bus.LOCKED}, (i == 3) ? 32'd0 : 32'd1);
        end
        check_val("lol_wordcnt", bus.WORD_COUNT, 32'd3);
        check_val("lol_state", {31'd0, bus.DBG_STATE}, 32'd0);

        // Relock on a fresh stream; no counting while searching.
        send(mk(10'd100));
        send(mk(10'd101));
        send(mk(10'd102));
        check_val("relock_pre", {31'd0, bus.LOCKED}, 32'd0);
        send(mk(10'd103));
        check_val("relock", {31'd0, bus.LOCKED}, 32'd1);
        check_val("relock_errcnt", {16'd0, bus.ERR_COUNT}, 32'd3);

        // CLR together with an error: pulse still fires, counters cleared.
        exp_q.push_back(32'd0);
        bus.CLR = 1'b1;
        send(mk(10'd200));
        bus.CLR = 1'b0;
        check_val("clr_err_pulse", {31'd0, bus.ERR_PULSE}, 32'd1);
        check_val("clr_err_errcnt", {16'd0, bus.ERR_COUNT}, 32'd0);
        check_val("clr_err_wordcnt", bus.WORD_COUNT, 32'd0);
        send(mk(10'd201));
        check_val("resync_pulse", {31'd0, bus.ERR_PULSE}, 32'd0);
        check_val("resync_wordcnt", bus.WORD_COUNT, 32'd1);

        // Asynchronous reset mid-stream, between clock edges.
        exp_q.push_back(32'h1234_5678);
        send(32'h1234_5678);
        check_val("pre_rst_pulse", {31'd0, bus.ERR_PULSE}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(mk(10'd500));
        send(mk(10'd501));
        send(mk(10'd502));
        check_val("post_rst_prelock", {31'd0, bus.LOCKED}, 32'd0);
        send(mk(10'd503));
        check_val("post_rst_lock", {31'd0, bus.LOCKED}, 32'd1);

        check_val("err_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
